watch_time_counter: RTL and testbench

//  Timekeeping core of the digital watch. Divides the system clock to a 1 Hz tick and keeps 24-hour time as six BCD digits (HH:MM:SS).
//  Two buttons set the time. Each digit output drives one 7-segment decoder directly.

---
 rtl/watch_pkg.sv | 15 +
 rtl/bcd_mod_counter.sv | 40 ++++
 rtl/watch_time_counter.sv | 118 +++++++++++
 tb/tb_watch_time_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared mode encoding and digit limits for the watch timekeeping core and its display logic.
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_BAD      = 2'd3
    } mode_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after tens==TENS_MAX, ones==ONES_MAX_AT_TENS_MAX.
module bcd_mod_counter #(
    parameter int TENS_MAX             = 5,
    parameter int ONES_MAX_AT_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic at_max;

    assign at_max = (tens == 4'(TENS_MAX)) && (ones == 4'(ONES_MAX_AT_TENS_MAX));
    assign carry  = inc && at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/watch_time_counter.sv
// Watch timekeeping core: 1 Hz prescaler, button edge detect, RUN/SET FSM and HH:MM:SS BCD counters.
module watch_time_counter
    import watch_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick_1hz,
    output logic [1:0] mode
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    mode_e         state, state_next;
    logic [PW-1:0] presc;
    logic          btn_mode_q, btn_inc_q;
    logic          mode_rise, inc_rise, inc_act;
    logic          exit_set;
    logic          sec_inc, sec_clr, sec_carry;
    logic          min_inc, min_carry;
    logic          hour_inc, hour_carry;

    assign mode_rise = btn_mode & ~btn_mode_q;
    assign inc_rise  = btn_inc & ~btn_inc_q;
    // A mode press on the same edge swallows the increment.
    assign inc_act   = inc_rise & ~mode_rise;
    assign exit_set  = (state == MODE_SET_MIN) && mode_rise;
    assign tick_1hz  = (presc == PRESC_MAX);
    assign mode      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            state      <= MODE_RUN;
        end else begin
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            state      <= state_next;
            if (exit_set || tick_1hz)
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MODE_RUN:      if (mode_rise) state_next = MODE_SET_HOUR;
            MODE_SET_HOUR: if (mode_rise) state_next = MODE_SET_MIN;
            MODE_SET_MIN:  if (mode_rise) state_next = MODE_RUN;
            default:       state_next = MODE_RUN;
        endcase
    end

    // Ticks only advance time in RUN; a tick on the RUN->SET_HOUR edge still counts.
    assign sec_inc  = (state == MODE_RUN) && tick_1hz;
    assign sec_clr  = exit_set;
    assign min_inc  = ((state == MODE_RUN) && sec_carry) ||
                      ((state == MODE_SET_MIN) && inc_act);
    assign hour_inc = ((state == MODE_RUN) && min_carry) ||
                      ((state == MODE_SET_HOUR) && inc_act);

    bcd_mod_counter #(
        .TENS_MAX             (SEC_MAX / 10),
        .ONES_MAX_AT_TENS_MAX (SEC_MAX % 10)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX             (MIN_MAX / 10),
        .ONES_MAX_AT_TENS_MAX (MIN_MAX % 10)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (1'b0),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX             (HOUR_MAX / 10),
        .ONES_MAX_AT_TENS_MAX (HOUR_MAX % 10)
    ) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hour_inc),
        .clr   (1'b0),
        .tens  (hour_tens),
        .ones  (hour_ones),
        .carry (hour_carry)
    );

    logic unused_carry;
    assign unused_carry = hour_carry;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed self-checking bench for watch_time_counter with a 4-cycle second.
module tb_watch_time_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc;
    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       tick_1hz;
    logic [1:0] mode;

    int n_checks = 0;
    int n_pass   = 0;

    watch_time_counter #(.CLK_HZ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hour_tens (hour_tens),
        .hour_ones (hour_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .tick_1hz  (tick_1hz),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_time(input string tag, input int exp);
        check(tag, int'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}), exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
            step();
        end
    endtask

    // Returns just after the edge that ends the next tick cycle.
    task automatic wait_tick();
        int n = 0;
        while (!tick_1hz && n < 16) begin
            step();
            n++;
        end
        if (n >= 16) check("tick_timeout", 0, 1);
        step();
    endtask

    task automatic run_secs(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // From RUN: add hour_incs to hours, min_incs to minutes, return to RUN with sec=00.
    task automatic set_hm(input int hour_incs, input int min_incs);
        press_mode();
        press_inc(hour_incs);
        press_mode();
        press_inc(min_incs);
        press_mode();
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        step();
        check_time("reset_digits", 32'h000000);
        check("reset_mode", mode, 0);
        check("reset_tick", tick_1hz, 0);
        rst_n = 1'b1;

        // Async reset mid-count at 12:34:56
        set_hm(12, 34);
        run_secs(56);
        check_time("preset_123456", 32'h123456);
        #2 rst_n = 1'b0;
        #1;
        check_time("async_reset_digits", 32'h000000);
        check("async_reset_mode", mode, 0);
        step();
        rst_n = 1'b1;

        // Tick cadence
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("tick_cycle_%0d", i), tick_1hz, (i == 4 || i == 8) ? 1 : 0);
            step();
        end
        check_time("after_8_cycles", 32'h000002);

        // Rollovers
        set_hm(23, 59);
        run_secs(59);
        check_time("pre_235959", 32'h235959);
        run_secs(1);
        check_time("roll_000000", 32'h000000);
        set_hm(9, 59);
        run_secs(59);
        check_time("pre_095959", 32'h095959);
        run_secs(1);
        check_time("roll_100000", 32'h100000);
        set_hm(9, 59);
        run_secs(59);
        check_time("pre_195959", 32'h195959);
        run_secs(1);
        check_time("roll_200000", 32'h200000);

        // Set modes
        press_mode();
        check("mode_set_hour", mode, 1);
        run_secs(3);
        check_time("frozen_3_ticks", 32'h200000);
        press_inc(2);
        check_time("hour_22", 32'h220000);
        press_inc(3);
        check_time("hour_wrap_01", 32'h010000);
        press_mode();
        check("mode_set_min", mode, 2);
        press_inc(58);
        check_time("min_58", 32'h015800);
        press_inc(61);
        check_time("min_61_incs", 32'h015900);

        // Exit SET_MIN with sec=37
        press_mode();
        check("mode_run_again", mode, 0);
        run_secs(37);
        check_time("run_37s", 32'h015937);
        press_mode();
        press_mode();
        check("mode_set_min_2", mode, 2);
        check_time("frozen_015937", 32'h015937);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        check("exit_mode", mode, 0);
        check_time("exit_sec_clr", 32'h015900);
        n = 0;
        while (!tick_1hz && n < 10) begin
            step();
            n++;
        end
        check("first_tick_cycle", n + 1, 4);

        // This mode press edge ends the tick cycle, so sec becomes 01
        press_mode();
        check("mode_set_hour_2", mode, 1);
        check_time("sec_counted_on_entry", 32'h015901);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        check("simul_mode", mode, 2);
        check_time("simul_no_inc", 32'h015901);
        btn_inc = 1'b1;
        repeat (10) step();
        btn_inc = 1'b0;
        step();
        check_time("held_inc_once", 32'h010001);
        check("held_mode", mode, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
